// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci index decoder and related sequence blocks:
// FSM state encoding, the known max index for 32-bit values, and a helper
// that derives the largest representable Fibonacci index for any width.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } fib_state_t;

  // Largest n with F(n) < 2**32, i.e. F(47) = 2971215073.
  localparam int unsigned FIB_MAX_IDX_32 = 47;

  // Largest n such that F(n) fits in 'width' unsigned bits (47 for 32, 93 for 64).
  function automatic int unsigned fib_max_idx(input int unsigned width);
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] t;
    int unsigned  n;
    a = '0;
    b = 128'd1;
    n = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      if ((b >> width) != '0) break;
      t = a + b;
      a = b;
      b = t;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fib_term_iter.sv
// Fibonacci term iterator: holds the current term a, the next term b and the
// index of a. 'clear' restarts at F(0); 'advance' steps to the next term.
// Terms are WIDTH+2 bits so stepping past any WIDTH-bit value never wraps.
module fib_term_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH+1:0] a,
  output logic [IDX_W-1:0] idx
);

  logic [WIDTH+1:0] b;

  // Term pair and index registers; clear takes priority over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= {{(WIDTH+1){1'b0}}, 1'b1};
      idx <= '0;
    end else if (clear) begin
      a   <= '0;
      b   <= {{(WIDTH+1){1'b0}}, 1'b1};
      idx <= '0;
    end else if (advance) begin
      a   <= b;
      b   <= a + b;
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/fibonacci_index_decoder.sv
// Fibonacci index decoder: accepts one WIDTH-bit value per transaction and
// reports whether it is a Fibonacci term and its index (hit: n with F(n)=value;
// miss: smallest n with F(n)>value). Latency is n+1 cycles from accept.
// Optional feature macro FIB_DEC_FLOOR_EN adds out_floor, the largest term <= value.
module fibonacci_index_decoder
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_fib,
  output logic [IDX_W-1:0] out_index
`ifdef FIB_DEC_FLOOR_EN
  ,
  output logic [WIDTH-1:0] out_floor
`endif
);

  // Index output must hold max index + 1 (the miss index past the last term).
  if ((fib_max_idx(WIDTH) + 1) >= (64'd1 << IDX_W)) begin : g_idx_w_check
    $error("IDX_W too narrow for WIDTH");
  end
  if (fib_max_idx(32) != FIB_MAX_IDX_32) begin : g_pkg_check
    $error("fib_max_idx inconsistent with FIB_MAX_IDX_32");
  end

  fib_state_t       state;
  fib_state_t       state_next;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH+1:0] term;
  logic [IDX_W-1:0] term_idx;
  logic             accept;
  logic             advance;
  logic             finish;
  logic             term_eq;
  logic             term_gt;

  fib_term_iter #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .advance (advance),
    .a       (term),
    .idx     (term_idx)
  );

  // Unsigned compare of the current term against the latched value.
  always_comb begin
    term_eq = (term == {2'b00, value_q});
    term_gt = (term >  {2'b00, value_q});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)            state_next = SEARCH;
      SEARCH:  if (term_eq || term_gt)  state_next = DONE;
      DONE:    if (out_ready)           state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // State-decoded handshakes and iterator controls.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = (state == IDLE) && in_valid;
    finish    = (state == SEARCH) && (term_eq || term_gt);
    advance   = (state == SEARCH) && !(term_eq || term_gt);
  end

  // Operand latch: in_value is sampled only at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (accept) begin
      value_q <= in_value;
    end
  end

  // Result registers, loaded on the final compare and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_is_fib <= 1'b0;
      out_index  <= '0;
    end else if (finish) begin
      out_is_fib <= term_eq;
      out_index  <= term_idx;
    end
  end

`ifdef FIB_DEC_FLOOR_EN
  logic [WIDTH-1:0] prev_term;

  // Previous term tracker: before advancing, a is always below value, so it fits WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_term <= '0;
    end else if (accept) begin
      prev_term <= '0;
    end else if (advance) begin
      prev_term <= term[WIDTH-1:0];
    end
  end

  // Floor result: the value itself on a hit, else the last term below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_floor <= '0;
    end else if (finish) begin
      out_floor <= term_eq ? value_q : prev_term;
    end
  end
`endif

endmodule
